fdd_head_stepper: RTL and testbench

FDD_HEAD_STEPPER -- requirements
Module: fdd_head_stepper

---
 rtl/fdd_pkg.sv | 23 ++
 rtl/fdd_sync2.sv | 30 +++
 rtl/fdd_head_stepper.sv | 202 ++++++++++++++++++++
 tb/tb_fdd_head_stepper.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fdd_pkg.sv
// Shared definitions for the floppy head stepper.
//   fdd_state_e  : stepper FSM states
//   PHASE_TABLE  : coil pattern per phase index. Even entries drive one coil,
//                  odd entries drive two coils (the half-step positions).
//   track_w()    : bit width needed for a track number
package fdd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_DWELL = 2'd2
  } fdd_state_e;

  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic int track_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fdd_sync2.sv
// Two-flop synchroniser for asynchronous controller inputs.
//   clk, rst : clock and synchronous active-high reset
//   d_i      : asynchronous input bus
//   q_o      : synchronised output; RST_VAL while in reset
module fdd_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fdd_head_stepper.sv
// Floppy drive head stepper. Turns FDC step/dir pulses into a four-phase coil
// sequence and keeps a track estimate.
//   clk, rst     : clock, synchronous active-high reset
//   drive_sel_n  : FDC drive selects (active-low); bit DRIVE_ID enables this unit
//   step_n/dir_n : FDC step pulse (active-low) and direction (1 = outward)
//   t00_sens     : track-0 sensor, high at track 0
//   step_coil    : coil drive pattern
//   track_0_n    : registered track-0 status to the FDC (active-low)
//   cur_track    : current track estimate
//   busy         : a move is running or requests are outstanding
//   step_err     : one-cycle pulse for a dropped or illegal request
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no move running; start, or consume a blocked request
// ST_PHASE | one cycle: advance the coil index
// ST_DWELL | let the head settle for the rest of the coil phase
module fdd_head_stepper
  import fdd_pkg::*;
#(
  parameter int NUM_DRIVES   = 4,
  parameter int DRIVE_ID     = 1,
  parameter int NUM_TRACKS   = 80,
  parameter int HALF_STEP    = 0,
  parameter int DWELL_CYCLES = 150000,
  parameter int QUEUE_DEPTH  = 7,
  parameter int HOLD_CYCLES  = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_DRIVES-1:0]           drive_sel_n,
  input  logic                            step_n,
  input  logic                            dir_n,
  input  logic                            t00_sens,
  output logic [3:0]                      step_coil,
  output logic                            track_0_n,
  output logic [track_w(NUM_TRACKS)-1:0]  cur_track,
  output logic                            busy,
  output logic                            step_err
);

  localparam int TW = track_w(NUM_TRACKS);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int NW = $clog2(QUEUE_DEPTH + 2) + 2;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [TW-1:0]        TRK_MAX    = TW'(NUM_TRACKS - 1);
  localparam logic [TW-1:0]        TRK_ONE    = TW'(1);
  // PHASE occupies the first cycle of each coil phase, DWELL the rest.
  localparam logic [DW-1:0]        DWELL_LOAD = DW'(DWELL_CYCLES - 2);
  localparam logic [HW-1:0]        HOLD_LOAD  = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [2:0]           IDX_STEP   = (HALF_STEP != 0) ? 3'd1 : 3'd2;
  localparam logic signed [NW-1:0] NET_P1     = NW'(1);
  localparam logic signed [NW-1:0] NET_M1     = NW'(-1);
  localparam logic signed [NW-1:0] QMAX       = NW'(QUEUE_DEPTH);
  localparam logic signed [NW-1:0] QMIN       = NW'(-QUEUE_DEPTH);

  logic                  step_s, dir_s, t00_s;
  logic [NUM_DRIVES-1:0] sel_s;
  logic                  unused_sel;
  logic                  selected, accept;

  fdd_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_step (.clk(clk), .rst(rst), .d_i(step_n),   .q_o(step_s));
  fdd_sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_dir  (.clk(clk), .rst(rst), .d_i(dir_n),    .q_o(dir_s));
  fdd_sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_t00  (.clk(clk), .rst(rst), .d_i(t00_sens), .q_o(t00_s));
  fdd_sync2 #(.WIDTH(NUM_DRIVES), .RST_VAL({NUM_DRIVES{1'b1}})) u_sync_sel (
    .clk(clk), .rst(rst), .d_i(drive_sel_n), .q_o(sel_s)
  );

  assign unused_sel = ^sel_s;

  fdd_state_e            state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [TW-1:0]         trk_q, trk_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic                  half_q, half_d;
  logic                  out_q, out_d;
  logic                  err_q, err_d;
  logic signed [NW-1:0]  net_q, net_d, net_dec, net_rem, net_base, net_try;
  logic                  step_prev_q;
  logic                  coil_en_q;
  logic [HW-1:0]         hold_q;
  logic                  t0n_q;

  assign selected = ~sel_s[DRIVE_ID];
  assign accept   = step_prev_q & ~step_s & selected;
  assign busy     = (state_q != ST_IDLE) || (net_q != '0);

  // net counts the move in flight as well as the queued ones; it is debited
  // by the direction actually travelled, so a cancellation that arrives
  // mid-move leaves a request to bring the head back.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    trk_d    = trk_q;
    dwell_d  = dwell_q;
    half_d   = half_q;
    out_d    = out_q;
    err_d    = 1'b0;
    net_dec  = '0;
    net_rem  = net_q;
    net_base = net_q;
    net_try  = net_q;
    net_d    = net_q;

    case (state_q)
      ST_IDLE: begin
        if (net_q != '0) begin
          if (net_q[NW-1] && t00_s) begin
            net_dec = NET_M1;
            trk_d   = '0;
          end else if (!net_q[NW-1] && trk_q == TRK_MAX) begin
            net_dec = NET_P1;
            err_d   = 1'b1;
          end else begin
            out_d   = net_q[NW-1];
            state_d = ST_PHASE;
          end
        end
      end
      ST_PHASE: begin
        idx_d   = out_q ? idx_q - IDX_STEP : idx_q + IDX_STEP;
        dwell_d = DWELL_LOAD;
        state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - DW'(1);
        end else if (HALF_STEP != 0 && !half_q) begin
          half_d  = 1'b1;
          state_d = ST_PHASE;
        end else begin
          half_d  = 1'b0;
          net_dec = out_q ? NET_M1 : NET_P1;
          net_rem = net_q - net_dec;
          if (!out_q)                       trk_d = trk_q + TRK_ONE;
          else if (t00_s || trk_q == '0)    trk_d = '0;
          else                              trk_d = trk_q - TRK_ONE;
          // A blocked follow-on request is handed to IDLE to be consumed.
          if (net_rem == '0 || (net_rem[NW-1] && t00_s) ||
              (!net_rem[NW-1] && trk_d == TRK_MAX)) begin
            state_d = ST_IDLE;
          end else begin
            out_d   = net_rem[NW-1];
            state_d = ST_PHASE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    net_base = net_q - net_dec;
    net_try  = net_base + (dir_s ? NET_M1 : NET_P1);
    net_d    = net_base;
    if (accept) begin
      if (net_try > QMAX || net_try < QMIN) err_d = 1'b1;
      else                                  net_d = net_try;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      trk_q       <= '0;
      dwell_q     <= '0;
      half_q      <= 1'b0;
      out_q       <= 1'b0;
      err_q       <= 1'b0;
      net_q       <= '0;
      step_prev_q <= 1'b1;
      coil_en_q   <= 1'b0;
      hold_q      <= '0;
      t0n_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      trk_q       <= trk_d;
      dwell_q     <= dwell_d;
      half_q      <= half_d;
      out_q       <= out_d;
      err_q       <= err_d;
      net_q       <= net_d;
      step_prev_q <= step_s;
      t0n_q       <= ~(t00_s & (trk_q == '0));
      // Hold timer runs only while idle and unselected; the index survives.
      if (busy || selected) begin
        coil_en_q <= 1'b1;
        hold_q    <= HOLD_LOAD;
      end else if (HOLD_CYCLES != 0 && coil_en_q) begin
        if (hold_q == '0) coil_en_q <= 1'b0;
        else              hold_q    <= hold_q - HW'(1);
      end
    end
  end

  assign step_coil = coil_en_q ? PHASE_TABLE[idx_q] : 4'b0000;
  assign cur_track = trk_q;
  assign track_0_n = t0n_q;
  assign step_err  = err_q;

endmodule

// File: tb/tb_fdd_head_stepper.sv
// Bench for fdd_head_stepper: directed scenarios plus randomized single
// requests checked against a track/phase-index reference model.
module tb_fdd_head_stepper;

  localparam int NT = 12;
  localparam int TW = 4;
  localparam int DWELL = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_h = 1'b1;
  logic [3:0] drive_sel_n = 4'b1111;
  logic step_n = 1'b1;
  logic dir_n = 1'b0;
  logic t00_sens = 1'b0;

  logic [3:0] step_coil, step_coil_h;
  logic track_0_n, track_0_n_h, busy, busy_h, step_err, step_err_h;
  logic [TW-1:0] cur_track, cur_track_h;

  always #5 clk = ~clk;

  fdd_head_stepper #(.NUM_DRIVES(4), .DRIVE_ID(1), .NUM_TRACKS(NT), .HALF_STEP(0),
                     .DWELL_CYCLES(DWELL), .QUEUE_DEPTH(7), .HOLD_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .drive_sel_n(drive_sel_n), .step_n(step_n), .dir_n(dir_n),
    .t00_sens(t00_sens), .step_coil(step_coil), .track_0_n(track_0_n),
    .cur_track(cur_track), .busy(busy), .step_err(step_err));

  fdd_head_stepper #(.NUM_DRIVES(4), .DRIVE_ID(1), .NUM_TRACKS(NT), .HALF_STEP(1),
                     .DWELL_CYCLES(DWELL), .QUEUE_DEPTH(7), .HOLD_CYCLES(5)) dut_h (
    .clk(clk), .rst(rst_h), .drive_sel_n(drive_sel_n), .step_n(step_n), .dir_n(dir_n),
    .t00_sens(t00_sens), .step_coil(step_coil_h), .track_0_n(track_0_n_h),
    .cur_track(cur_track_h), .busy(busy_h), .step_err(step_err_h));

  logic [3:0] spec_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0100, 4'b1100, 4'b1000, 4'b1001};

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int err_cnt = 0, err_cnt_h = 0;
  logic [3:0] last_coil = 4'b0000, last_coil_h = 4'b0000;
  logic [3:0] log_val[$], log_val_h[$];
  int log_cyc[$], log_cyc_h[$];

  int m_trk, m_idx, m_err, base;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step_err === 1'b1) err_cnt++;
    if (step_err_h === 1'b1) err_cnt_h++;
    if (step_coil !== last_coil) begin
      log_val.push_back(step_coil); log_cyc.push_back(cyc); last_coil = step_coil;
    end
    if (step_coil_h !== last_coil_h) begin
      log_val_h.push_back(step_coil_h); log_cyc_h.push_back(cyc); last_coil_h = step_coil_h;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic outward);
    dir_n = outward; step_n = 1'b0; tick(1);
    step_n = 1'b1; tick(1);
  endtask

  task automatic wait_idle(input bit h);
    int n;
    tick(5);
    n = 0;
    while (((h ? busy_h : busy) === 1'b1) && n < 400) begin tick(1); n++; end
    check(h ? "idle_timeout_h" : "idle_timeout", {31'd0, (h ? busy_h : busy)}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
  endtask

  // One isolated request; the model knows only tracks, index and limits.
  task automatic model_step(input bit outward, input bit sel_on);
    t00_sens = (m_trk == 0);
    drive_sel_n = sel_on ? 4'b1101 : 4'b1111;
    tick(4);
    check("rand_trk0n", {31'd0, track_0_n}, (m_trk == 0) ? 32'd0 : 32'd1);
    pulse(outward);
    wait_idle(1'b0);
    if (sel_on) begin
      if (outward) begin
        if (m_trk != 0) begin m_trk--; m_idx = (m_idx + 6) % 8; end
      end else begin
        if (m_trk == NT - 1) m_err++;
        else begin m_trk++; m_idx = (m_idx + 2) % 8; end
      end
    end
    check("rand_track", {28'd0, cur_track}, m_trk);
    check("rand_coil", {28'd0, step_coil}, {28'd0, spec_tbl[m_idx]});
    check("rand_err", err_cnt - base, m_err);
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_coil", {28'd0, step_coil}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, step_err}, 32'd0);
    check("rst_trk0n", {31'd0, track_0_n}, 32'd1);
    check("rst_track", {28'd0, cur_track}, 32'd0);
    rst = 1'b0;

    // Three inward pulses: full-step sequence, 10 cycles per phase
    drive_sel_n = 4'b1101; tick(4);
    check("t1_coil_init", {28'd0, step_coil}, 32'h1);
    log_val.delete(); log_cyc.delete();
    base = err_cnt;
    for (int i = 0; i < 3; i++) pulse(1'b0);
    wait_idle(1'b0);
    check("t1_nchanges", log_val.size(), 3);
    if (log_val.size() == 3) begin
      check("t1_coil_a", {28'd0, log_val[0]}, 32'h2);
      check("t1_coil_b", {28'd0, log_val[1]}, 32'h4);
      check("t1_coil_c", {28'd0, log_val[2]}, 32'h8);
      check("t1_hold_a", log_cyc[1] - log_cyc[0], DWELL);
      check("t1_hold_b", log_cyc[2] - log_cyc[1], DWELL);
    end
    check("t1_track", {28'd0, cur_track}, 32'd3);
    check("t1_err", err_cnt - base, 0);

    // Burst of nine inward pulses overflows the queue once
    do_reset(); tick(4);
    base = err_cnt;
    for (int i = 0; i < 9; i++) pulse(1'b0);
    wait_idle(1'b0);
    check("t2_err", err_cnt - base, 1);
    check("t2_track", {28'd0, cur_track}, 32'd8);
    check("t2_coil", {28'd0, step_coil}, {28'd0, spec_tbl[0]});

    // Outward toward track 0 with the sensor active
    do_reset(); t00_sens = 1'b0; tick(4);
    pulse(1'b0); pulse(1'b0);
    wait_idle(1'b0);
    check("t3_track2", {28'd0, cur_track}, 32'd2);
    t00_sens = 1'b1; tick(4);
    base = err_cnt;
    pulse(1'b1);
    wait_idle(1'b0); tick(2);
    check("t3_track0", {28'd0, cur_track}, 32'd0);
    check("t3_trk0n", {31'd0, track_0_n}, 32'd0);
    check("t3_err_a", err_cnt - base, 0);
    pulse(1'b1);
    wait_idle(1'b0);
    check("t3_coil_still", {28'd0, step_coil}, {28'd0, spec_tbl[4]});
    check("t3_err_b", err_cnt - base, 0);
    check("t3_track_still", {28'd0, cur_track}, 32'd0);
    t00_sens = 1'b0;

    // Half-step unit: one track is two 10-cycle phases; then coil hold timeout
    rst_h = 1'b0; tick(4);
    check("t4_coil_init", {28'd0, step_coil_h}, 32'h1);
    log_val_h.delete(); log_cyc_h.delete();
    pulse(1'b0);
    wait_idle(1'b1);
    check("t4_nchanges", log_val_h.size(), 2);
    if (log_val_h.size() == 2) begin
      check("t4_coil_a", {28'd0, log_val_h[0]}, 32'h3);
      check("t4_coil_b", {28'd0, log_val_h[1]}, 32'h2);
      check("t4_hold", log_cyc_h[1] - log_cyc_h[0], DWELL);
    end
    check("t4_track", {28'd0, cur_track_h}, 32'd1);
    check("t4_err", err_cnt_h, 0);
    drive_sel_n = 4'b1111; tick(3);
    check("t4_hold_on", {28'd0, step_coil_h}, 32'h2);
    tick(7);
    check("t4_hold_off", {28'd0, step_coil_h}, 32'h0);
    drive_sel_n = 4'b1101; tick(4);
    check("t4_reenergise", {28'd0, step_coil_h}, 32'h2);
    rst_h = 1'b1;

    // Deselected pulses ignored; reset in the middle of a dwell
    drive_sel_n = 4'b1111;
    do_reset();
    base = err_cnt;
    pulse(1'b0); pulse(1'b0); tick(8);
    check("t5_desel_busy", {31'd0, busy}, 32'd0);
    check("t5_desel_track", {28'd0, cur_track}, 32'd0);
    check("t5_desel_coil", {28'd0, step_coil}, 32'd0);
    drive_sel_n = 4'b1101; tick(4);
    pulse(1'b0); tick(5);
    check("t5_moving", {31'd0, busy}, 32'd1);
    rst = 1'b1; tick(1);
    check("t5_rst_coil", {28'd0, step_coil}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_err", {31'd0, step_err}, 32'd0);
    check("t5_rst_trk0n", {31'd0, track_0_n}, 32'd1);
    check("t5_rst_track", {28'd0, cur_track}, 32'd0);
    drive_sel_n = 4'b1111; tick(2);
    rst = 1'b0; tick(6);
    check("t5_no_resid_err", err_cnt - base, 0);
    check("t5_post_busy", {31'd0, busy}, 32'd0);

    // Reference-model phase: climb past the top track, then random requests
    t00_sens = 1'b1;
    drive_sel_n = 4'b1101;
    do_reset();
    m_trk = 0; m_idx = 0; m_err = 0; base = err_cnt;
    for (int i = 0; i < NT; i++) model_step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      model_step($urandom_range(0, 99) < 45, $urandom_range(0, 9) != 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
